// File: rtl/alu_seq.sv
// Handshaked ALU with registered results, branch flag and optional iterative divider.
// Define ALU_DIVIDER_EN to build MOD/DIV as a WIDTH-cycle restoring divider.
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter int SHAMT_IMM = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inTwo,
  input  logic             fourShift,
  output logic             outValid,
  output logic [WIDTH-1:0] result,
  output logic             branchCompPass,
  output logic             divByZero,
  output logic             fsm_state
);

  // Handshake: a request transfers on a rising edge where inValid && inReady;
  // outValid is a single-cycle pulse with no backpressure from the consumer.

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_SRL   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_SEQ   = 5'b00101;
  localparam logic [4:0] OP_SLRA  = 5'b00110;
  localparam logic [4:0] OP_PASSA = 5'b00111;
  localparam logic [4:0] OP_PASSB = 5'b01000;
  localparam logic [4:0] OP_MOD   = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_BZ    = 5'b10100;
  localparam logic [4:0] OP_BNZ   = 5'b11000;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] SHAMT_V = WIDTH'(SHAMT_IMM);

  logic             accept;
  logic [WIDTH-1:0] amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_bcp;
  logic             alu_dbz;

  assign accept = inValid && inReady;

  // Single-cycle result; for MOD/DIV this is only used when the divider is bypassed.
  always_comb begin
    alu_res = '0;
    alu_bcp = 1'b0;
    alu_dbz = 1'b0;
    amt     = fourShift ? SHAMT_V : inTwo;
    case (OP)
      OP_ADD:   alu_res = inOne + inTwo;
      OP_SUB:   alu_res = inOne - inTwo;
      OP_SLL:   alu_res = (amt >= WIDTH_V) ? '0 : (inOne << amt);
      OP_SRL:   alu_res = (amt >= WIDTH_V) ? '0 : (inOne >> amt);
      OP_AND:   alu_res = inOne & inTwo;
      OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, inOne == inTwo};
      OP_SLRA:  alu_res = (inOne << 4) + inTwo;
      OP_PASSA: alu_res = inOne;
      OP_PASSB: alu_res = inTwo;
      OP_MOD: begin
`ifdef ALU_DIVIDER_EN
        alu_res = (inTwo == '0) ? inOne : '0;
`endif
        alu_dbz = (inTwo == '0);
      end
      OP_DIV: begin
`ifdef ALU_DIVIDER_EN
        alu_res = (inTwo == '0) ? '1 : '0;
`endif
        alu_dbz = (inTwo == '0);
      end
      OP_BZ: begin
        if (inOne == '0) begin
          alu_res = inTwo;
          alu_bcp = 1'b1;
        end
      end
      OP_BNZ: begin
        if (inOne != '0) begin
          alu_res = inTwo;
          alu_bcp = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef ALU_DIVIDER_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd, dvs, rem, rem_nxt, dvd_nxt;
  logic [WIDTH:0]   rem_sh;
  logic             qbit, last, start_div, is_mod;

  assign start_div = accept && ((OP == OP_MOD) || (OP == OP_DIV)) && (inTwo != '0);
  assign last      = (count == CW'(WIDTH - 1));
  assign inReady   = (state == ST_IDLE) && !reset;
  assign fsm_state = (state == ST_DIV);

  // Quotient bits shift into the dividend register as its MSBs are consumed.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    qbit    = (rem_sh >= {1'b0, dvs});
    rem_nxt = qbit ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_div) state_nxt = ST_DIV;
      ST_DIV:  if (last)      state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      result         <= '0;
      outValid       <= 1'b0;
      branchCompPass <= 1'b0;
      divByZero      <= 1'b0;
      count          <= '0;
      dvd            <= '0;
      dvs            <= '0;
      rem            <= '0;
      is_mod         <= 1'b0;
    end else begin
      outValid <= 1'b0;
      if (start_div) begin
        dvd    <= inOne;
        dvs    <= inTwo;
        rem    <= '0;
        count  <= '0;
        is_mod <= (OP == OP_MOD);
      end else if (accept) begin
        result         <= alu_res;
        branchCompPass <= alu_bcp;
        divByZero      <= alu_dbz;
        outValid       <= 1'b1;
      end else if (state == ST_DIV) begin
        dvd   <= dvd_nxt;
        rem   <= rem_nxt;
        count <= count + 1'b1;
        if (last) begin
          result         <= is_mod ? rem_nxt : dvd_nxt;
          branchCompPass <= 1'b0;
          divByZero      <= 1'b0;
          outValid       <= 1'b1;
          count          <= '0;
        end
      end
    end
  end
`else
  assign inReady   = !reset;
  assign fsm_state = 1'b0;

  always_ff @(posedge CLK) begin
    if (reset) begin
      result         <= '0;
      outValid       <= 1'b0;
      branchCompPass <= 1'b0;
      divByZero      <= 1'b0;
    end else begin
      outValid <= accept;
      if (accept) begin
        result         <= alu_res;
        branchCompPass <= alu_bcp;
        divByZero      <= alu_dbz;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random requests scored against a behavioural model,
// checking result, flags, latency, hold behaviour and reset values.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int SH = 4;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLL = 5'b00010, SRL = 5'b00011;
  localparam logic [4:0] AND_OP = 5'b00100, SEQ = 5'b00101, SLRA = 5'b00110, PASSA = 5'b00111;
  localparam logic [4:0] PASSB = 5'b01000, MOD = 5'b01001, DIV = 5'b01010;
  localparam logic [4:0] BZ = 5'b10100, BNZ = 5'b11000;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         inValid = 1'b0;
  logic         fourShift = 1'b0;
  logic [4:0]   OP = '0;
  logic [W-1:0] inOne = '0;
  logic [W-1:0] inTwo = '0;
  logic         inReady, outValid, branchCompPass, divByZero, fsm_state;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   flag_q[$];
  int           cyc_q[$];

  alu_seq #(.WIDTH(W), .SHAMT_IMM(SH)) dut (
    .CLK(CLK), .reset(reset), .inValid(inValid), .inReady(inReady), .OP(OP),
    .inOne(inOne), .inTwo(inTwo), .fourShift(fourShift), .outValid(outValid),
    .result(result), .branchCompPass(branchCompPass), .divByZero(divByZero),
    .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: returns {result, branch flag, div-by-zero flag}.
  function automatic logic [W+1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic fs);
    logic [W-1:0] r;
    logic         bcp, dbz;
    int           amt;
    r = '0; bcp = 1'b0; dbz = 1'b0;
    amt = fs ? SH : int'(b);
    case (op)
      ADD:    r = a + b;
      SUB:    r = a - b;
      SLL:    r = (amt >= W) ? '0 : (a << amt);
      SRL:    r = (amt >= W) ? '0 : (a >> amt);
      AND_OP: r = a & b;
      SEQ:    r[0] = (a == b);
      SLRA:   r = (a << 4) + b;
      PASSA:  r = a;
      PASSB:  r = b;
      MOD: begin
        dbz = (b == 0);
`ifdef ALU_DIVIDER_EN
        r = (b == 0) ? a : a % b;
`endif
      end
      DIV: begin
        dbz = (b == 0);
`ifdef ALU_DIVIDER_EN
        r = (b == 0) ? '1 : a / b;
`endif
      end
      BZ:  if (a == 0) begin r = b; bcp = 1'b1; end
      BNZ: if (a != 0) begin r = b; bcp = 1'b1; end
      default: r = '0;
    endcase
    return {r, bcp, dbz};
  endfunction

  function automatic int lat(input logic [4:0] op, input logic [W-1:0] b);
`ifdef ALU_DIVIDER_EN
    if ((op == MOD || op == DIV) && b != 0) return W;
`endif
    return 1;
  endfunction

  function automatic int busy_cycles();
`ifdef ALU_DIVIDER_EN
    return W;
`else
    return 0;
`endif
  endfunction

  // driver
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic fs);
    int g;
    logic [W+1:0] m;
    g = 0;
    @(negedge CLK);
    while (!inReady && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (!inReady) begin
      total++; bad++;
      $display("FAIL ready_timeout: inReady got 0 expected 1");
    end else begin
      m = model(op, a, b, fs);
      OP = op; inOne = a; inTwo = b; fourShift = fs; inValid = 1'b1;
      exp_q.push_back(m[W+1:2]);
      flag_q.push_back(m[1:0]);
      cyc_q.push_back(cyc + lat(op, b));
    end
  endtask

  task automatic busy_len(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    inValid = 1'b0;
    while (!inReady && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check(name, n, busy_cycles());
  endtask

  // scoreboard: one compare point per cycle, after the falling edge
  logic         rst_last = 1'b1;
  logic [W-1:0] last_res = '0;
  logic         last_bcp = 1'b0, last_dbz = 1'b0;

  always begin
    logic [W-1:0] er;
    logic [1:0]   ef;
    int           ec;
    @(negedge CLK);
    #1;
    if (rst_last) begin
      check("reset_out_valid", outValid, 0);
      check("reset_result", result, 0);
      check("reset_branch", branchCompPass, 0);
      check("reset_div_by_zero", divByZero, 0);
      exp_q.delete(); flag_q.delete(); cyc_q.delete();
      last_res = '0; last_bcp = 1'b0; last_dbz = 1'b0;
    end else if (outValid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        last_res = result; last_bcp = branchCompPass; last_dbz = divByZero;
      end else begin
        er = exp_q.pop_front();
        ef = flag_q.pop_front();
        ec = cyc_q.pop_front();
        check("result", result, er);
        check("branch_comp_pass", branchCompPass, ef[1]);
        check("div_by_zero", divByZero, ef[0]);
        check("latency_cycle", cyc, ec);
        last_res = er; last_bcp = ef[1]; last_dbz = ef[0];
      end
    end else begin
      check("hold_result", result, last_res);
      check("hold_branch", branchCompPass, last_bcp);
      check("hold_div_by_zero", divByZero, last_dbz);
    end
    rst_last = reset;
  end

  logic [4:0] op_tab[14] = '{ADD, SUB, SLL, SRL, AND_OP, SEQ, SLRA, PASSA, PASSB,
                             MOD, DIV, BZ, BNZ, 5'b11111};

  initial begin
    logic [W+1:0] m;
    int           g, idx;
    logic [4:0]   op;
    logic [W-1:0] a, b;

    // hand-computed pins on the model itself
    m = model(ADD, 8'd200, 8'd100, 1'b0);  check("pin_add", m[W+1:2], 44);
    m = model(SUB, 8'd5, 8'd7, 1'b0);      check("pin_sub", m[W+1:2], 254);
    m = model(SLL, 8'h0F, 8'd0, 1'b1);     check("pin_sll", m[W+1:2], 8'hF0);
    m = model(SRL, 8'h80, 8'd9, 1'b0);     check("pin_srl", m[W+1:2], 0);
    m = model(SLRA, 8'h03, 8'h05, 1'b0);   check("pin_slra", m[W+1:2], 8'h35);
    m = model(BZ, 8'h00, 8'h35, 1'b0);     check("pin_bz", m, {8'h35, 2'b10});
    m = model(BNZ, 8'h00, 8'h35, 1'b0);    check("pin_bnz", m, {8'h00, 2'b00});
`ifdef ALU_DIVIDER_EN
    m = model(MOD, 8'd100, 8'd7, 1'b0);    check("pin_mod", m[W+1:2], 2);
    m = model(DIV, 8'd100, 8'd7, 1'b0);    check("pin_div", m[W+1:2], 14);
    m = model(DIV, 8'd9, 8'd0, 1'b0);      check("pin_div0", m, {8'hFF, 2'b01});
`else
    m = model(MOD, 8'd100, 8'd7, 1'b0);    check("pin_mod_off", m[W+1:2], 0);
    m = model(DIV, 8'd9, 8'd0, 1'b0);      check("pin_div0_off", m, {8'h00, 2'b01});
`endif

    repeat (3) @(negedge CLK);
    reset = 1'b0;
    #1 check("ready_after_reset", inReady, 1);

    // directed
    send(ADD, 8'd200, 8'd100, 1'b0);
    send(SUB, 8'd5, 8'd7, 1'b0);
    send(MOD, 8'd100, 8'd7, 1'b0);
    busy_len("mod_busy_cycles");
    send(DIV, 8'd100, 8'd7, 1'b0);
    busy_len("div_busy_cycles");
    send(DIV, 8'd9, 8'd0, 1'b0);
    send(ADD, 8'd1, 8'd1, 1'b0);
    send(BZ, 8'h00, 8'h35, 1'b0);
    send(BNZ, 8'h00, 8'h35, 1'b0);
    send(AND_OP, 8'hF0, 8'h3C, 1'b0);
    send(SLL, 8'h0F, 8'h00, 1'b1);
    send(SRL, 8'h80, 8'd9, 1'b0);
    send(SLRA, 8'h03, 8'h05, 1'b0);

    // reset aborts a divide in flight
    send(DIV, 8'd200, 8'd3, 1'b0);
    @(negedge CLK);
    inValid = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    #1 check("ready_after_abort", inReady, 1);
    send(ADD, 8'd3, 8'd4, 1'b0);

    // random stream, with inValid left high while busy and occasional gaps
    for (int i = 0; i < 200; i++) begin
      idx = $urandom_range(0, 14);
      op  = (idx == 14) ? 5'($urandom_range(0, 31)) : op_tab[idx];
      a   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      send(op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        inValid = 1'b0;
      end
    end

    @(negedge CLK);
    inValid = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: pending results got %0d expected 0", exp_q.size());
    end
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
